bus_master_port: RTL

//  Master-side serial bus interface; one instance per master 0..11, upstream of bus_controller.

---
 rtl/bus_master_port.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// Master-side serial bus port: requests the bus, shifts out header/write data,
// shifts in read data, and resumes split reads when the arbiter re-grants.
module bus_master_port #(
  parameter int unsigned SID_W       = 3,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [SID_W-1:0]  cmd_sid,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              m_req,
  input  logic              m_grant,
  output logic              bus_util,
  output logic              bus_out,
  output logic              bus_out_en,
  input  logic              bus_in,
  input  logic              slave_ack,
  input  logic              slave_split
);

  localparam int unsigned HdrW = SID_W + ADDR_W + 1;
  localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0]      HdrLast  = 5'(HdrW - 1);
  localparam logic [4:0]      DataLast = 5'(DATA_W - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StReq, StTxHdr, StWaitAck, StTxData, StRxData, StSplitWait, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [HdrW-1:0]   tx_sr_q, tx_sr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    tx_sr_d    = tx_sr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    m_req      = 1'b0;
    bus_util   = 1'b0;
    bus_out_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          tx_sr_d = {cmd_sid, cmd_addr, cmd_write};
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        m_req = 1'b1;
        if (m_grant) begin
          bit_cnt_d = '0;
          state_d   = StTxHdr;
        end
      end
      StTxHdr: begin
        bus_util   = 1'b1;
        bus_out_en = 1'b1;
        tx_sr_d    = tx_sr_q << 1;
        bit_cnt_d  = bit_cnt_q + 5'd1;
        if (bit_cnt_q == HdrLast) begin
          bit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = StWaitAck;
        end
      end
      StWaitAck: begin
        bus_util = 1'b1;
        tmo_d    = tmo_q + 1'b1;
        if (slave_ack) begin
          // Preload write data MSB-aligned; harmless for reads.
          tx_sr_d                     = '0;
          tx_sr_d[HdrW-1 -: DATA_W]   = wdata_q;
          bit_cnt_d                   = '0;
          state_d                     = write_q ? StTxData : StRxData;
        end else if (slave_split && !write_q) begin
          state_d = StSplitWait;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StTxData: begin
        bus_util   = 1'b1;
        bus_out_en = 1'b1;
        tx_sr_d    = tx_sr_q << 1;
        bit_cnt_d  = bit_cnt_q + 5'd1;
        if (bit_cnt_q == DataLast) begin
          bit_cnt_d = '0;
          state_d   = StResp;
        end
      end
      StRxData: begin
        bus_util  = 1'b1;
        rdata_d   = {rdata_q[DATA_W-2:0], bus_in};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == DataLast) begin
          bit_cnt_d = '0;
          state_d   = StResp;
        end
      end
      StSplitWait: begin
        // Re-grant resumes straight into data; no fresh request or header.
        if (m_grant) begin
          bit_cnt_d = '0;
          state_d   = StRxData;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus_out   = bus_out_en & tx_sr_q[HdrW-1];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      tx_sr_q   <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      tx_sr_q   <= tx_sr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule
